// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP transmitter: FSM state encoding,
// pixel width and byte ordering of an RGB565 pixel on the 8-bit bus.
package dvp_pkg;

    localparam int RGB565_W      = 16;
    localparam bit BYTE_HI_FIRST = 1'b1;

    // Frame phases, in the order a frame walks through them
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } dvp_state_e;

    // Byte driven on the even (first) clock of a pixel slot
    function automatic logic [7:0] first_byte(input logic [RGB565_W-1:0] pix);
        return BYTE_HI_FIRST ? pix[15:8] : pix[7:0];
    endfunction

    // Byte held for the odd (second) clock of a pixel slot
    function automatic logic [7:0] second_byte(input logic [RGB565_W-1:0] pix);
        return BYTE_HI_FIRST ? pix[7:0] : pix[15:8];
    endfunction

endpackage

// File: rtl/dvp_timing.sv
// Horizontal/vertical counters for the DVP transmitter. Counters sit at zero
// while the frame is not running, so the first running cycle is hcnt=0 of
// line 0 of the current phase. The vertical counter counts lines within the
// current phase and wraps at the phase length supplied by the FSM.
module dvp_timing #(
    parameter logic [13:0] LINE_LEN = 14'd2720
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_i,
    input  logic [11:0] phase_lines_i,
    output logic [13:0] hcnt_o,
    output logic        phase_end_o
);

    logic [13:0] hcnt_q;
    logic [11:0] vcnt_q;
    logic        line_end;

    // Last clock of a line, and last clock of the last line of the phase
    always_comb begin
        line_end    = run_i && (hcnt_q == LINE_LEN - 14'd1);
        phase_end_o = line_end && (vcnt_q == phase_lines_i - 12'd1);
        hcnt_o      = hcnt_q;
    end

    // Pixel-clock counter with line wrap; line counter restarts each phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= 14'd0;
            vcnt_q <= 12'd0;
        end else if (!run_i) begin
            hcnt_q <= 14'd0;
            vcnt_q <= 12'd0;
        end else if (line_end) begin
            hcnt_q <= 14'd0;
            vcnt_q <= phase_end_o ? 12'd0 : vcnt_q + 12'd1;
        end else begin
            hcnt_q <= hcnt_q + 14'd1;
        end
    end

endmodule

// File: rtl/dvp_tx.sv
// DVP (camera-style) transmitter: turns a stream of RGB565 pixels into
// cmos_vsync / cmos_href / 8-bit cmos_db with clk doubling as pclk.
//
// Pixel handshake: a pixel transfers in a cycle where pix_valid and
// pix_ready are both high. pix_ready is only raised together with pix_valid,
// so pix_ready alone means "the presented pixel was taken this cycle".
// Outside IDLE the transmitter never stalls: a pixel slot with no valid
// pixel is sent as two zero bytes and flagged as underflow.
//
// All line counts (VS_LINES, V_BACK, V_DISP, V_FRONT) must be at least 1.
module dvp_tx
    import dvp_pkg::*;
#(
    parameter logic [11:0] H_DISP   = 12'd1280,
    parameter logic [11:0] V_DISP   = 12'd720,
    parameter logic [11:0] H_BLANK  = 12'd160,
    parameter logic [3:0]  VS_LINES = 4'd2,
    parameter logic [7:0]  V_BACK   = 8'd20,
    parameter logic [7:0]  V_FRONT  = 8'd5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr,
    input  logic [RGB565_W-1:0] pix_data,
    input  logic                pix_valid,
    input  logic                pix_sof,
    output logic                pix_ready,
    output logic                cmos_vsync,
    output logic                cmos_href,
    output logic [7:0]          cmos_db,
    output logic                frame_done,
    output logic                underflow,
    output logic                sof_err
);

    localparam logic [13:0] LINE_LEN  = 14'(2 * H_DISP + H_BLANK);
    localparam logic [13:0] ACT_BYTES = 14'(2 * H_DISP);

    dvp_state_e  state_q;
    logic        vsync_q;
    logic        href_q;
    logic [7:0]  db_q;
    logic [7:0]  lo_q;
    logic        first_q;
    logic        underflow_q, underflow_d;
    logic        sof_err_q, sof_err_d;

    logic [13:0] hcnt;
    logic        phase_end;
    logic [11:0] phase_lines;
    logic        run;
    logic        in_act_bytes;
    logic        slot;
    logic        odd;
    logic        start;
    logic        idle_drop;
    logic        take;
    logic        miss;
    logic        sof_bad;

    dvp_timing #(
        .LINE_LEN (LINE_LEN)
    ) u_timing (
        .clk           (clk),
        .rst_n         (rst_n),
        .run_i         (run),
        .phase_lines_i (phase_lines),
        .hcnt_o        (hcnt),
        .phase_end_o   (phase_end)
    );

    // Phase length seen by the line counter, and per-cycle slot decode
    always_comb begin
        phase_lines = 12'd1;
        case (state_q)
            ST_VSYNC:  phase_lines = 12'(VS_LINES);
            ST_VBACK:  phase_lines = 12'(V_BACK);
            ST_ACTIVE: phase_lines = V_DISP;
            ST_VFRONT: phase_lines = 12'(V_FRONT);
            default:   phase_lines = 12'd1;
        endcase

        run          = (state_q != ST_IDLE);
        in_act_bytes = (state_q == ST_ACTIVE) && (hcnt < ACT_BYTES);
        slot         = in_act_bytes && !hcnt[0];
        odd          = in_act_bytes && hcnt[0];

        // The SOF pixel that starts a frame is left in place for the first slot
        start        = (state_q == ST_IDLE) && en && pix_valid && pix_sof;
        idle_drop    = (state_q == ST_IDLE) && pix_valid && !pix_sof;
        take         = slot && pix_valid;
        miss         = slot && !pix_valid;
        sof_bad      = take && !first_q && pix_sof;

        // Gated by rst_n so the handshake is silent while reset is held
        pix_ready    = rst_n && (idle_drop || take);
        frame_done   = (state_q == ST_VFRONT) && phase_end;
    end

    // Frame FSM; vsync is registered so it tracks the VSYNC phase exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vsync_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_VSYNC;
                        vsync_q <= 1'b1;
                    end
                end
                ST_VSYNC: begin
                    if (phase_end) begin
                        state_q <= ST_VBACK;
                        vsync_q <= 1'b0;
                    end
                end
                ST_VBACK: begin
                    if (phase_end) state_q <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (phase_end) state_q <= ST_VFRONT;
                end
                ST_VFRONT: begin
                    if (phase_end) state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    vsync_q <= 1'b0;
                end
            endcase
        end
    end

    // Byte path: first byte on the slot clock, held second byte on the next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            href_q  <= 1'b0;
            db_q    <= 8'h00;
            lo_q    <= 8'h00;
            first_q <= 1'b0;
        end else begin
            if (start) begin
                first_q <= 1'b1;
            end else if (take) begin
                first_q <= 1'b0;
            end

            if (slot) begin
                href_q <= 1'b1;
                if (pix_valid) begin
                    db_q <= first_byte(pix_data);
                    lo_q <= second_byte(pix_data);
                end else begin
                    db_q <= 8'h00;
                    lo_q <= 8'h00;
                end
            end else if (odd) begin
                href_q <= 1'b1;
                db_q   <= lo_q;
            end else begin
                href_q <= 1'b0;
                db_q   <= 8'h00;
            end
        end
    end

    // Sticky error flags: a new event in the same cycle as clr wins
    always_comb begin
        underflow_d = (underflow_q && !clr) || miss;
        sof_err_d   = (sof_err_q && !clr) || sof_bad;
    end

    // Error flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_q <= 1'b0;
            sof_err_q   <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
            sof_err_q   <= sof_err_d;
        end
    end

    assign cmos_vsync = vsync_q;
    assign cmos_href  = href_q;
    assign cmos_db    = db_q;
    assign underflow  = underflow_q;
    assign sof_err    = sof_err_q;

endmodule

// File: tb/tb_dvp_tx.sv
// Bench for dvp_tx with a small frame geometry (L = 11 clocks, 55-clock
// frame). Expected outputs come from frame-cycle arithmetic plus a byte
// queue filled as pixels are offered.
module tb_dvp_tx;

    localparam int HD   = 4;
    localparam int VD   = 2;
    localparam int HB   = 3;
    localparam int VS   = 1;
    localparam int VB   = 1;
    localparam int VF   = 1;
    localparam int L    = 2 * HD + HB;
    localparam int ACT_START = (VS + VB) * L + 1;
    localparam int FRAME     = (VS + VB + VD + VF) * L;
    localparam int NPIX      = HD * VD;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_sof;
    logic        pix_ready;
    logic        cmos_vsync;
    logic        cmos_href;
    logic [7:0]  cmos_db;
    logic        frame_done;
    logic        underflow;
    logic        sof_err;

    logic [7:0]  exp_q[$];
    bit          exp_uf;
    bit          exp_se;
    int          n_checks;
    int          n_pass;

    dvp_tx #(
        .H_DISP   (12'(HD)),
        .V_DISP   (12'(VD)),
        .H_BLANK  (12'(HB)),
        .VS_LINES (4'(VS)),
        .V_BACK   (8'(VB)),
        .V_FRONT  (8'(VF))
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clr        (clr),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_ready  (pix_ready),
        .cmos_vsync (cmos_vsync),
        .cmos_href  (cmos_href),
        .cmos_db    (cmos_db),
        .frame_done (frame_done),
        .underflow  (underflow),
        .sof_err    (sof_err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Idle cycles with a fixed input pattern; no frame may start
    task automatic idle_cycles(input int n, input bit en_v, input bit valid, input bit sof);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("idle_vsync", cmos_vsync, 0);
            check("idle_href", cmos_href, 0);
            check("idle_db", cmos_db, 0);
            check("idle_underflow", underflow, exp_uf);
            check("idle_sof_err", sof_err, exp_se);
            en        = en_v;
            clr       = 1'b0;
            pix_valid = valid;
            pix_sof   = sof;
            pix_data  = 16'($urandom);
            #1;
            check("idle_ready", pix_ready, valid & ~sof);
            check("idle_done", frame_done, 0);
        end
    endtask

    // One frame: c=0 is the IDLE cycle presenting the SOF pixel, c=1..FRAME the frame
    task automatic run_frame(input int pre_drop, input logic [7:0] gap_mask,
                             input logic [7:0] sof_mask, input int clr_at,
                             input int en_off_at, input int rst_at, input bit rnd);
        logic [15:0] pix [NPIX];
        bit first;
        for (int p = 0; p < NPIX; p++)
            pix[p] = rnd ? 16'($urandom) : {8'hA1 + 8'(2 * p), 8'hB2 + 8'(2 * p)};
        if (pre_drop > 0) idle_cycles(pre_drop, 1'b1, 1'b1, 1'b0);
        first = 1'b1;
        for (int c = 0; c <= FRAME; c++) begin
            int s, r, h, p;
            bit exp_href, slot, exp_ready, miss, sbad, clr_now;
            logic [7:0] eb;
            @(posedge clk); #1;
            s = c - 1;
            exp_href = 1'b0;
            if (c >= 1 && s >= ACT_START && s < ACT_START + VD * L)
                exp_href = ((s - ACT_START) % L) < 2 * HD;
            check("vsync", cmos_vsync, (c >= 1 && c <= VS * L));
            check("href", cmos_href, exp_href);
            if (exp_href) begin
                if (exp_q.size() > 0) eb = exp_q.pop_front();
                else eb = 8'hxx;
                check("db", cmos_db, eb);
            end else begin
                check("db_blank", cmos_db, 8'h00);
            end
            check("underflow", underflow, exp_uf);
            check("sof_err", sof_err, exp_se);

            en      = (en_off_at > 0 && c >= en_off_at) ? 1'b0 : 1'b1;
            clr_now = (c == clr_at);
            clr     = clr_now;
            slot = 1'b0;
            p = 0;
            if (c >= ACT_START && c < ACT_START + VD * L) begin
                r = c - ACT_START;
                h = r % L;
                if (h < 2 * HD && (h % 2) == 0) begin
                    slot = 1'b1;
                    p = (r / L) * HD + h / 2;
                end
            end
            if (c == 0) begin
                pix_valid = 1'b1;
                pix_sof   = 1'b1;
                pix_data  = pix[0];
            end else if (slot && !gap_mask[p]) begin
                pix_valid = 1'b1;
                pix_sof   = (p == 0) || sof_mask[p];
                pix_data  = pix[p];
            end else if (slot) begin
                pix_valid = 1'b0;
                pix_sof   = 1'($urandom_range(0, 1));
                pix_data  = 16'($urandom);
            end else begin
                pix_valid = 1'($urandom_range(0, 1));
                pix_sof   = 1'($urandom_range(0, 1));
                pix_data  = 16'($urandom);
            end

            exp_ready = slot && pix_valid;
            miss      = slot && !pix_valid;
            sbad      = exp_ready && !first && pix_sof;
            if (exp_ready) first = 1'b0;
            if (slot) begin
                if (pix_valid) begin
                    exp_q.push_back(pix[p][15:8]);
                    exp_q.push_back(pix[p][7:0]);
                end else begin
                    exp_q.push_back(8'h00);
                    exp_q.push_back(8'h00);
                end
            end
            #1;
            check("pix_ready", pix_ready, exp_ready);
            check("frame_done", frame_done, (c == FRAME));

            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_vsync", cmos_vsync, 0);
                check("rst_href", cmos_href, 0);
                check("rst_db", cmos_db, 0);
                check("rst_ready", pix_ready, 0);
                check("rst_done", frame_done, 0);
                check("rst_underflow", underflow, 0);
                check("rst_sof_err", sof_err, 0);
                exp_q.delete();
                exp_uf = 1'b0;
                exp_se = 1'b0;
                pix_valid = 1'b0;
                clr = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end

            exp_uf = (exp_uf && !clr_now) || miss;
            exp_se = (exp_se && !clr_now) || sbad;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        exp_uf    = 1'b0;
        exp_se    = 1'b0;
        rst_n     = 1'b0;
        en        = 1'b0;
        clr       = 1'b0;
        pix_data  = 16'h0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        #1;
        check("reset_vsync", cmos_vsync, 0);
        check("reset_href", cmos_href, 0);
        check("reset_db", cmos_db, 0);
        check("reset_ready", pix_ready, 0);
        check("reset_done", frame_done, 0);
        check("reset_underflow", underflow, 0);
        check("reset_sof_err", sof_err, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Continuous A1B2.. pixels
        run_frame(0, 8'h00, 8'h00, -1, -1, -1, 1'b0);
        // Missing 2nd pixel of the first line
        run_frame(0, 8'h02, 8'h00, -1, -1, -1, 1'b0);
        // Three non-SOF pixels dropped ahead of the SOF
        run_frame(3, 8'h00, 8'h00, -1, -1, -1, 1'b0);
        // SOF on 3rd pixel, clr late in the frame
        run_frame(0, 8'h00, 8'h04, 50, -1, -1, 1'b0);
        // clr in the same cycle as an underflow: set wins
        run_frame(0, 8'h02, 8'h00, ACT_START + 2, -1, -1, 1'b1);
        // Randomized frames
        for (int i = 0; i < 6; i++) begin
            logic [7:0] g, sm;
            int ca;
            g  = 8'($urandom) & 8'hFE;
            sm = 8'($urandom) & 8'hFE;
            ca = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, FRAME));
            run_frame(int'($urandom_range(0, 3)), g, sm, ca, -1, -1, 1'b1);
        end
        // en dropped mid-frame: frame completes, none follows
        run_frame(0, 8'h00, 8'h00, -1, 20, -1, 1'b1);
        idle_cycles(15, 1'b0, 1'b1, 1'b1);
        // Reset in the middle of the active region
        run_frame(0, 8'h00, 8'h00, -1, -1, 30, 1'b1);
        idle_cycles(5, 1'b1, 1'b1, 1'b0);
        run_frame(2, 8'h00, 8'h00, -1, -1, -1, 1'b1);
        idle_cycles(3, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
